// File: rtl/snake_pkg.sv
// Shared constants for the snake game display path: MSM state encoding,
// default colours and default screen geometry.
package snake_pkg;

  // Master state machine encoding as seen on the MSM_State bus.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GAME = 2'b01,
    WIN  = 2'b10,
    LOSE = 2'b11
  } msm_state_e;

  // Default 12-bit RGB colours.
  localparam logic [11:0] COLOUR_BLUE  = 12'h00F;
  localparam logic [11:0] COLOUR_RED   = 12'hF00;
  localparam logic [11:0] COLOUR_BLACK = 12'h000;

  // Default 640x480 screen geometry.
  localparam int unsigned SCREEN_W        = 640;
  localparam int unsigned SCREEN_H        = 480;
  localparam int unsigned SCREEN_H_CENTRE = 320;
  localparam int unsigned SCREEN_V_CENTRE = 240;

endpackage

// File: rtl/frame_pattern_gen.sv
// Frame-rate counters for the colour compositor: WIN frame counter, LOSE
// flash counter/phase and the post-state-change blanking counter. All inputs
// are already stage-1 registered, so a tick and a state change presented in
// the same input cycle are seen here in the same cycle.
module frame_pattern_gen
  import snake_pkg::*;
#(
  parameter int unsigned FLASH_FRAMES = 30,
  parameter int unsigned BLANK_FRAMES = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tick_i,
  input  msm_state_e state_i,
  input  logic       state_change_i,
  output logic [7:0] fc_hi_o,
  output logic       flash_phase_o,
  output logic       blank_active_o
);

  localparam int unsigned FW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam int unsigned BW = (BLANK_FRAMES > 0) ? $clog2(BLANK_FRAMES + 1) : 1;
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_FRAMES - 1);
  localparam logic [BW-1:0] BLANK_LOAD = BW'(BLANK_FRAMES);

  logic [15:0]   fc_q, fc_d;
  logic [FW-1:0] flash_cnt_q, flash_cnt_d;
  logic          flash_phase_q, flash_phase_d;
  logic [BW-1:0] blank_q, blank_d;
  logic          enter_win_s, enter_lose_s;

  assign enter_win_s  = state_change_i && (state_i == WIN);
  assign enter_lose_s = state_change_i && (state_i == LOSE);

  // WIN frame counter: cleared on entry to WIN, counts ticks while in WIN.
  always_comb begin
    fc_d = fc_q;
    if (enter_win_s) begin
      fc_d = 16'h0000;
    end else if (tick_i && (state_i == WIN)) begin
      fc_d = fc_q + 16'd1;
    end else begin
      fc_d = fc_q;
    end
  end

  // LOSE flash: restart red on entry, toggle phase every FLASH_FRAMES ticks.
  always_comb begin
    flash_cnt_d   = flash_cnt_q;
    flash_phase_d = flash_phase_q;
    if (enter_lose_s) begin
      flash_cnt_d   = '0;
      flash_phase_d = 1'b1;
    end else if (tick_i && (state_i == LOSE)) begin
      if (flash_cnt_q == FLASH_LAST) begin
        flash_cnt_d   = '0;
        flash_phase_d = ~flash_phase_q;
      end else begin
        flash_cnt_d   = flash_cnt_q + FW'(1);
        flash_phase_d = flash_phase_q;
      end
    end else begin
      flash_cnt_d   = flash_cnt_q;
      flash_phase_d = flash_phase_q;
    end
  end

  // Blank counter: full reload on any state change (reload beats a tick).
  always_comb begin
    blank_d = blank_q;
    if (state_change_i) begin
      blank_d = BLANK_LOAD;
    end else if (tick_i && (blank_q != '0)) begin
      blank_d = blank_q - BW'(1);
    end else begin
      blank_d = blank_q;
    end
  end

  // Counter state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fc_q          <= 16'h0000;
      flash_cnt_q   <= '0;
      flash_phase_q <= 1'b0;
      blank_q       <= '0;
    end else begin
      fc_q          <= fc_d;
      flash_cnt_q   <= flash_cnt_d;
      flash_phase_q <= flash_phase_d;
      blank_q       <= blank_d;
    end
  end

  // On the change cycle itself the registers still hold old values, so the
  // entry values are forwarded so the very first pixel of a new state is right.
  assign fc_hi_o        = enter_win_s ? 8'h00 : fc_q[15:8];
  assign flash_phase_o  = enter_lose_s ? 1'b1 : flash_phase_q;
  assign blank_active_o = (blank_q != '0) || (state_change_i && (BLANK_LOAD != '0));

endmodule

// File: rtl/colour_compositor.sv
// Final colour output stage between the snake renderer and the VGA block.
// Two-stage pipeline: stage 1 registers the pixel inputs, stage 2 selects the
// colour from the MSM state and registers it with an aligned valid.
module colour_compositor
  import snake_pkg::*;
#(
  parameter int unsigned     CW           = 12,
  parameter int unsigned     XW           = 10,
  parameter int unsigned     YW           = 9,
  parameter int unsigned     H_CENTRE     = SCREEN_H_CENTRE,
  parameter int unsigned     V_CENTRE     = SCREEN_V_CENTRE,
  parameter logic [CW-1:0]   IDLE_COLOUR  = COLOUR_BLUE,
  parameter logic [CW-1:0]   LOSE_COLOUR  = COLOUR_RED,
  parameter int unsigned     FLASH_FRAMES = 30,
  parameter int unsigned     BLANK_FRAMES = 8
) (
  input  logic                 CLK,
  input  logic                 RESETN,
  input  logic [CW-1:0]        COLOUR_IN,
  input  logic [XW+YW-1:0]     ADDR,
  input  logic                 PIXEL_VALID,
  input  logic                 FRAME_TICK,
  input  logic [1:0]           MSM_State,
  output logic [CW-1:0]        COLOUR_OUT,
  output logic                 COLOUR_VALID
);

  localparam int unsigned AW = XW + YW;
  localparam int unsigned DW = ((XW > YW) ? XW : YW) + 1;
  localparam int unsigned SW = (CW > DW + 2) ? CW : DW + 2;
  localparam logic [DW-1:0] HC = DW'(H_CENTRE);
  localparam logic [DW-1:0] VC = DW'(V_CENTRE);

  // Stage 1 registers.
  logic [AW-1:0] addr_q;
  logic [CW-1:0] colour_in_q;
  logic          valid_q;
  logic          tick_q;
  msm_state_e    state_q;
  msm_state_e    prev_state_q;

  // Stage 2 registers.
  logic [CW-1:0] colour_out_q, colour_out_d;
  logic          colour_valid_q;

  // Stage 1 combinational results.
  logic [DW-1:0] x_s, y_s, dx_s, dy_s;
  logic [SW-1:0] sum_s;
  logic [CW-1:0] pattern_s;
  logic          state_change_s;
  logic [7:0]    fc_hi_s;
  logic          flash_phase_s;
  logic          blank_active_s;

  // Stage 1: capture the pixel and state; previous state starts at IDLE so
  // coming out of reset in IDLE does not blank the screen.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      addr_q       <= '0;
      colour_in_q  <= '0;
      valid_q      <= 1'b0;
      tick_q       <= 1'b0;
      state_q      <= IDLE;
      prev_state_q <= IDLE;
    end else begin
      addr_q       <= ADDR;
      colour_in_q  <= COLOUR_IN;
      valid_q      <= PIXEL_VALID;
      tick_q       <= FRAME_TICK;
      state_q      <= msm_state_e'(MSM_State);
      prev_state_q <= state_q;
    end
  end

  assign state_change_s = (state_q != prev_state_q);

  assign x_s  = DW'(addr_q[AW-1:YW]);
  assign y_s  = DW'(addr_q[YW-1:0]);
  assign dx_s = (x_s >= HC) ? (x_s - HC) : (HC - x_s);
  assign dy_s = (y_s >= VC) ? (y_s - VC) : (VC - y_s);

  // WIN pattern: radial bands drifting with the frame count, wrapping at CW bits.
  assign sum_s     = SW'(fc_hi_s) + SW'(dx_s) + SW'(dy_s);
  assign pattern_s = sum_s[CW-1:0];

  frame_pattern_gen #(
    .FLASH_FRAMES (FLASH_FRAMES),
    .BLANK_FRAMES (BLANK_FRAMES)
  ) u_frame_pattern_gen (
    .clk_i          (CLK),
    .rst_ni         (RESETN),
    .tick_i         (tick_q),
    .state_i        (state_q),
    .state_change_i (state_change_s),
    .fc_hi_o        (fc_hi_s),
    .flash_phase_o  (flash_phase_s),
    .blank_active_o (blank_active_s)
  );

  // Stage 2 colour select: invisible pixels and blanking force black first.
  always_comb begin
    colour_out_d = '0;
    if (!valid_q) begin
      colour_out_d = '0;
    end else if (blank_active_s) begin
      colour_out_d = '0;
    end else begin
      case (state_q)
        IDLE:    colour_out_d = IDLE_COLOUR;
        GAME:    colour_out_d = colour_in_q;
        WIN:     colour_out_d = pattern_s;
        LOSE:    colour_out_d = flash_phase_s ? LOSE_COLOUR : '0;
        default: colour_out_d = '0;
      endcase
    end
  end

  // Stage 2 output registers.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      colour_out_q   <= '0;
      colour_valid_q <= 1'b0;
    end else begin
      colour_out_q   <= colour_out_d;
      colour_valid_q <= valid_q;
    end
  end

  assign COLOUR_OUT   = colour_out_q;
  assign COLOUR_VALID = colour_valid_q;

endmodule

// File: tb/tb_colour_compositor.sv
// Self-checking bench for colour_compositor (BLANK_FRAMES=3, FLASH_FRAMES=2).
// Expected outputs are pushed to a scoreboard queue when inputs are driven
// and compared two cycles later.
module tb_colour_compositor;
  import snake_pkg::*;

  localparam int BLANK = 3;
  localparam int FLASH = 2;

  logic        CLK = 1'b0;
  logic        RESETN;
  logic [11:0] COLOUR_IN;
  logic [18:0] ADDR;
  logic        PIXEL_VALID;
  logic        FRAME_TICK;
  logic [1:0]  MSM_State;
  logic [11:0] COLOUR_OUT;
  logic        COLOUR_VALID;

  colour_compositor #(
    .FLASH_FRAMES (FLASH),
    .BLANK_FRAMES (BLANK)
  ) dut (
    .CLK          (CLK),
    .RESETN       (RESETN),
    .COLOUR_IN    (COLOUR_IN),
    .ADDR         (ADDR),
    .PIXEL_VALID  (PIXEL_VALID),
    .FRAME_TICK   (FRAME_TICK),
    .MSM_State    (MSM_State),
    .COLOUR_OUT   (COLOUR_OUT),
    .COLOUR_VALID (COLOUR_VALID)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [11:0] colour;
    logic        valid;
    string       tag;
  } exp_t;

  typedef struct {
    logic [1:0]  st;
    logic [11:0] col;
    int          x;
    int          y;
    logic        pv;
    logic [11:0] exp;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[12];
  int   tests_run    = 0;
  int   tests_failed = 0;

  // Reference model state: input-level previous state and ticks seen since
  // the last state change (a tick coinciding with the change is not counted).
  logic [1:0] m_prev;
  int         m_ticks;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] model_colour(input logic [1:0] st, input logic [11:0] col,
                                               input int x, input int y, input logic pv, input int t);
    int dx, dy;
    if (!pv) return 12'h000;
    if (t < BLANK) return 12'h000;
    case (st)
      2'b00: return 12'h00F;
      2'b01: return col;
      2'b10: begin
        dx = (x > 320) ? x - 320 : 320 - x;
        dy = (y > 240) ? y - 240 : 240 - y;
        return 12'(((t / 256) % 256) + dx + dy);
      end
      default: return (((t / FLASH) % 2) == 0) ? 12'hF00 : 12'h000;
    endcase
  endfunction

  task automatic model_reset();
    sb_q.delete();
    m_prev  = 2'b00;
    m_ticks = BLANK;
  endtask

  // One clock cycle: check the output due now, drive new inputs, push expectation.
  // fixed_exp >= 0 supplies a table value instead of the model value.
  task automatic cycle(input string tag, input logic [1:0] st, input logic [11:0] col,
                       input int x, input int y, input logic pv, input logic tk,
                       input int fixed_exp);
    exp_t e;
    logic [9:0] xv;
    logic [8:0] yv;
    @(negedge CLK);
    if (sb_q.size() >= 2) begin
      e = sb_q.pop_front();
      check({e.tag, "_colour"}, 32'(COLOUR_OUT), 32'(e.colour));
      check({e.tag, "_valid"}, 32'(COLOUR_VALID), 32'(e.valid));
    end
    xv = x[9:0];
    yv = y[8:0];
    MSM_State   = st;
    COLOUR_IN   = col;
    ADDR        = {xv, yv};
    PIXEL_VALID = pv;
    FRAME_TICK  = tk;
    if (st != m_prev) m_ticks = 0;
    e.tag   = tag;
    e.valid = pv;
    e.colour = (fixed_exp >= 0) ? 12'(fixed_exp) : model_colour(st, col, x, y, pv, m_ticks);
    if ((st == m_prev) && tk) m_ticks++;
    m_prev = st;
    sb_q.push_back(e);
  endtask

  // One tick cycle followed by n quiet cycles.
  task automatic frame(input string tag, input logic [1:0] st, input logic [11:0] col,
                       input int x, input int y, input int n);
    cycle(tag, st, col, x, y, 1'b1, 1'b1, -1);
    for (int i = 0; i < n; i++) cycle(tag, st, col, x, y, 1'b1, 1'b0, -1);
  endtask

  initial begin
    vecs[0]  = '{2'b01, 12'hABC, 5,    5,   1'b1, 12'hABC};
    vecs[1]  = '{2'b01, 12'h000, 100,  50,  1'b1, 12'h000};
    vecs[2]  = '{2'b01, 12'hFFF, 639,  479, 1'b1, 12'hFFF};
    vecs[3]  = '{2'b01, 12'h5A5, 1023, 511, 1'b0, 12'h000};
    vecs[4]  = '{2'b01, 12'h123, 0,    0,   1'b1, 12'h123};
    vecs[5]  = '{2'b01, 12'h800, 320,  240, 1'b1, 12'h800};
    vecs[6]  = '{2'b10, 12'h000, 325,  238, 1'b1, 12'h008};
    vecs[7]  = '{2'b10, 12'hFFF, 320,  240, 1'b1, 12'h001};
    vecs[8]  = '{2'b10, 12'h000, 0,    0,   1'b1, 12'h231};
    vecs[9]  = '{2'b10, 12'h000, 639,  479, 1'b1, 12'h22F};
    vecs[10] = '{2'b10, 12'h000, 1023, 511, 1'b1, 12'h3CF};
    vecs[11] = '{2'b10, 12'h000, 325,  238, 1'b0, 12'h000};

    RESETN = 1'b0; COLOUR_IN = 12'h000; ADDR = '0; PIXEL_VALID = 1'b0;
    FRAME_TICK = 1'b0; MSM_State = 2'b00;
    model_reset();
    repeat (3) @(negedge CLK);
    check("reset_colour", 32'(COLOUR_OUT), 32'h0);
    check("reset_valid", 32'(COLOUR_VALID), 32'h0);
    RESETN = 1'b1;

    // IDLE straight out of reset: blue, no blanking.
    for (int i = 0; i < 4; i++) cycle("idle_boot", 2'b00, 12'h777, 10, 10, 1'b1, 1'b0, -1);

    // IDLE->GAME with a coincident tick: 3 ticks of black; second change at tick 2.
    cycle("chg_tick", 2'b01, 12'h456, 10, 10, 1'b1, 1'b1, -1);
    for (int i = 0; i < 3; i++) cycle("blank_a", 2'b01, 12'h456, 10, 10, 1'b1, 1'b0, -1);
    frame("blank_a", 2'b01, 12'h456, 10, 10, 3);
    cycle("rechg", 2'b00, 12'h456, 10, 10, 1'b1, 1'b1, -1);
    for (int i = 0; i < 3; i++) cycle("blank_b", 2'b00, 12'h456, 10, 10, 1'b1, 1'b0, -1);
    for (int f = 0; f < 4; f++) frame("blank_b", 2'b00, 12'h456, 10, 10, 2);

    // Back to GAME, wait out blanking, then pass-through table and latency probe.
    cycle("to_game", 2'b01, 12'h321, 20, 20, 1'b1, 1'b0, -1);
    for (int f = 0; f < 4; f++) frame("game_blank", 2'b01, 12'h321, 20, 20, 1);
    for (int i = 0; i < 6; i++)
      cycle("game_tbl", vecs[i].st, vecs[i].col, vecs[i].x, vecs[i].y, vecs[i].pv, 1'b0, int'(vecs[i].exp));
    cycle("lat_pre", 2'b01, 12'h000, 1, 1, 1'b0, 1'b0, 0);
    cycle("lat_abc", 2'b01, 12'hABC, 1, 1, 1'b1, 1'b0, 32'hABC);
    cycle("lat_post", 2'b01, 12'h000, 1, 1, 1'b0, 1'b0, 0);

    // PIXEL_VALID held low, then toggled, in IDLE.
    for (int i = 0; i < 4; i++) cycle("idle_pv0", 2'b00, 12'hFFF, 1023, 511, 1'b0, 1'b0, -1);
    for (int f = 0; f < 3; f++) frame("idle_settle", 2'b00, 12'h000, 1, 1, 1);
    for (int i = 0; i < 8; i++) cycle("pv_toggle", 2'b00, 12'h000, 1, 1, 1'(i % 2), 1'b0, -1);

    // WIN: 256 ticks after entry, then pattern table.
    cycle("to_win", 2'b10, 12'h000, 0, 0, 1'b1, 1'b0, -1);
    for (int f = 0; f < 256; f++) frame("win_run", 2'b10, 12'h000, 0, 0, 1);
    for (int i = 6; i < 12; i++)
      cycle("win_tbl", vecs[i].st, vecs[i].col, vecs[i].x, vecs[i].y, vecs[i].pv, 1'b0, int'(vecs[i].exp));

    // LOSE entered on a tick: red, black, red... then a held tick.
    cycle("to_lose", 2'b11, 12'h000, 3, 3, 1'b1, 1'b1, -1);
    for (int f = 0; f < 8; f++) frame("lose_flash", 2'b11, 12'h000, 3, 3, 2);
    for (int i = 0; i < 8; i++) cycle("lose_held", 2'b11, 12'h000, 3, 3, 1'b1, 1'b1, -1);

    // Asynchronous reset in the middle of a visible WIN frame.
    cycle("to_win2", 2'b10, 12'h000, 0, 0, 1'b1, 1'b0, -1);
    for (int f = 0; f < 4; f++) frame("win2", 2'b10, 12'h000, 0, 0, 1);
    cycle("win2_vis", 2'b10, 12'h000, 0, 0, 1'b1, 1'b0, -1);
    cycle("win2_vis", 2'b10, 12'h000, 0, 0, 1'b1, 1'b0, -1);
    cycle("win2_vis", 2'b10, 12'h000, 0, 0, 1'b1, 1'b0, -1);
    check("pre_rst_valid", 32'(COLOUR_VALID), 32'h1);
    #2;
    RESETN = 1'b0;
    MSM_State = 2'b00;
    #1;
    check("async_rst_colour", 32'(COLOUR_OUT), 32'h0);
    check("async_rst_valid", 32'(COLOUR_VALID), 32'h0);
    model_reset();
    repeat (2) @(negedge CLK);
    RESETN = 1'b1;
    for (int i = 0; i < 5; i++) cycle("idle_after_rst", 2'b00, 12'h000, 7, 7, 1'b1, 1'b0, -1);

    // Drain the last checked entries.
    cycle("drain", 2'b00, 12'h000, 0, 0, 1'b0, 1'b0, -1);
    cycle("drain", 2'b00, 12'h000, 0, 0, 1'b0, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
